// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the MEM-stage data-memory access unit:
//   - RV32 load/store FUNC3 encodings
//   - access FSM state enum
//   - access-size classification and misalignment helpers
// No ports (package).
// -----------------------------------------------------------------------------
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_NONE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Reserved encodings (011, 110, 111) behave as a full word.
    function automatic size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            F3_W:        return SZ_W;
            default:     return SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3_size(f3))
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// -----------------------------------------------------------------------------
// load_formatter
// Combinational load-data alignment and extension for RV32 loads. Selects the
// byte at off or the halfword at off[1] and sign/zero-extends by FUNC3.
// Reserved FUNC3 codes pass the full word through.
// Ports:
//   rdata  in  32  raw word read from memory
//   off    in  2   byte offset within the word (ADDRESS[1:0])
//   func3  in  3   load size/sign encoding
//   data   out 32  formatted load result
// -----------------------------------------------------------------------------
module load_formatter
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  func3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        case (func3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage data-memory responder for an RV32IM pipeline. Takes the EX/MEM
// memory request, runs it on a req/ack bus, generates byte enables and
// lane-replicated store data, formats load data and stalls the pipeline until
// the access finishes (or times out).
//
// Optional feature macro: MEM_ACCESS_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses skip the bus and pulse MISALIGNED
//   undefined : MISALIGNED stays 0, low address bits are truncated
//
// Parameters: TIMEOUT (1..255 wait cycles without ACK), ADDR_W (address width)
// Ports:
//   CLK, RST (async active-low)
//   MEM_READ, MEM_WRITE, FUNC3, ADDRESS, WRITE_DATA   request from EX/MEM
//   BUS_REQ, BUS_WE, BUS_ADDR, BUS_BE, BUS_WDATA      bus request side
//   BUS_RDATA, BUS_ACK                                bus response side
//   STALL                                             pipeline freeze
//   LOAD_DATA, LOAD_VALID                             formatted load result
//   BUS_ERROR, MISALIGNED                             one-cycle status pulses
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MEM_READ,
    input  logic              MEM_WRITE,
    input  logic [2:0]        FUNC3,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [31:0]       WRITE_DATA,
    output logic              BUS_REQ,
    output logic              BUS_WE,
    output logic [ADDR_W-1:0] BUS_ADDR,
    output logic [3:0]        BUS_BE,
    output logic [31:0]       BUS_WDATA,
    input  logic [31:0]       BUS_RDATA,
    input  logic              BUS_ACK,
    output logic              STALL,
    output logic [31:0]       LOAD_DATA,
    output logic              LOAD_VALID,
    output logic              BUS_ERROR,
    output logic              MISALIGNED
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [2:0]        func3_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [7:0]        cnt_q;
    logic [31:0]       load_data_q;
    logic              err_q;
    logic              mis_q;

    logic              req;
    logic              mis_req;
    logic              tmo_hit;
    logic [31:0]       fmt_data;

    function automatic logic [3:0] gen_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3_size(f3))
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] gen_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3_size(f3))
            SZ_B:    return {4{d[7:0]}};
            SZ_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    assign req     = MEM_READ | MEM_WRITE;
    assign tmo_hit = (cnt_q == TMO_LAST);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign mis_req = is_misaligned(FUNC3, ADDRESS[1:0]);
`else
    assign mis_req = 1'b0;
`endif

    load_formatter u_load_formatter (
        .rdata (BUS_RDATA),
        .off   (off_q),
        .func3 (func3_q),
        .data  (fmt_data)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ACK wins over a timeout that expires in the same cycle.
    always_comb begin
        state_nxt  = state;
        BUS_REQ    = 1'b0;
        STALL      = 1'b0;
        LOAD_VALID = 1'b0;
        BUS_ERROR  = 1'b0;
        MISALIGNED = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    STALL     = 1'b1;
                    state_nxt = mis_req ? DONE : WAIT;
                end
            end
            WAIT: begin
                BUS_REQ = 1'b1;
                STALL   = 1'b1;
                if (BUS_ACK || tmo_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                LOAD_VALID = ~we_q & ~err_q & ~mis_q;
                BUS_ERROR  = err_q;
                MISALIGNED = mis_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // While reset is held, release the pipeline even if EX/MEM still
        // presents a request.
        STALL = STALL & RST;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addr_q      <= '0;
            off_q       <= 2'b00;
            func3_q     <= 3'b000;
            we_q        <= 1'b0;
            be_q        <= BE_NONE;
            wdata_q     <= 32'd0;
            cnt_q       <= 8'd0;
            load_data_q <= 32'd0;
            err_q       <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= {ADDRESS[ADDR_W-1:2], 2'b00};
                        off_q   <= ADDRESS[1:0];
                        func3_q <= FUNC3;
                        we_q    <= MEM_WRITE & ~MEM_READ;
                        be_q    <= gen_be(FUNC3, ADDRESS[1:0]);
                        wdata_q <= gen_wdata(FUNC3, WRITE_DATA);
                        cnt_q   <= 8'd0;
                        err_q   <= 1'b0;
                        mis_q   <= mis_req;
                        if (mis_req) begin
                            load_data_q <= 32'd0;
                        end
                    end
                end
                WAIT: begin
                    if (BUS_ACK) begin
                        if (!we_q) begin
                            load_data_q <= fmt_data;
                        end
                    end else if (tmo_hit) begin
                        err_q       <= 1'b1;
                        load_data_q <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUS_WE    = we_q;
    assign BUS_ADDR  = addr_q;
    assign BUS_BE    = be_q;
    assign BUS_WDATA = wdata_q;
    assign LOAD_DATA = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        MEM_READ = 1'b0;
    logic        MEM_WRITE = 1'b0;
    logic [2:0]  FUNC3 = 3'b000;
    logic [31:0] ADDRESS = 32'd0;
    logic [31:0] WRITE_DATA = 32'd0;
    logic        BUS_REQ;
    logic        BUS_WE;
    logic [31:0] BUS_ADDR;
    logic [3:0]  BUS_BE;
    logic [31:0] BUS_WDATA;
    logic [31:0] BUS_RDATA = 32'd0;
    logic        BUS_ACK = 1'b0;
    logic        STALL;
    logic [31:0] LOAD_DATA;
    logic        LOAD_VALID;
    logic        BUS_ERROR;
    logic        MISALIGNED;

    always #5 CLK = ~CLK;

    mem_access_unit #(.TIMEOUT(16), .ADDR_W(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .MEM_READ   (MEM_READ),
        .MEM_WRITE  (MEM_WRITE),
        .FUNC3      (FUNC3),
        .ADDRESS    (ADDRESS),
        .WRITE_DATA (WRITE_DATA),
        .BUS_REQ    (BUS_REQ),
        .BUS_WE     (BUS_WE),
        .BUS_ADDR   (BUS_ADDR),
        .BUS_BE     (BUS_BE),
        .BUS_WDATA  (BUS_WDATA),
        .BUS_RDATA  (BUS_RDATA),
        .BUS_ACK    (BUS_ACK),
        .STALL      (STALL),
        .LOAD_DATA  (LOAD_DATA),
        .LOAD_VALID (LOAD_VALID),
        .BUS_ERROR  (BUS_ERROR),
        .MISALIGNED (MISALIGNED)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_wait;   // WAIT cycles before ACK; large = never
        logic [31:0] exp_baddr;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          exp_req;
        int          exp_stall;
        logic        exp_lv;
        logic        exp_err;
        logic        exp_mis;
        logic        chk_load;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int ack_wait,
                       input logic [31:0] exp_baddr, input logic exp_we,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                       input int exp_req, input int exp_stall, input logic exp_lv,
                       input logic exp_err, input logic exp_mis,
                       input logic chk_load, input logic [31:0] exp_load);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.ack_wait = ack_wait; v.exp_baddr = exp_baddr;
        v.exp_we = exp_we; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
        v.exp_req = exp_req; v.exp_stall = exp_stall; v.exp_lv = exp_lv;
        v.exp_err = exp_err; v.exp_mis = exp_mis; v.chk_load = chk_load;
        v.exp_load = exp_load;
        vecs.push_back(v);
    endtask

    // Drives one access starting at a falling edge and follows it to DONE.
    task automatic run_vec(input vec_t v, input int idx);
        int  stall_cnt = 0;
        int  req_cnt = 0;
        int  wait_cyc = 0;
        bit  done = 0;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge CLK);
        MEM_READ = v.rd; MEM_WRITE = v.wr; FUNC3 = v.f3; ADDRESS = v.addr;
        WRITE_DATA = v.wdata; BUS_RDATA = v.rdata; BUS_ACK = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (cyc > 0 && !STALL) begin
                done = 1;
                check({tag, " done_req"}, 32'(BUS_REQ), 32'd0);
                check({tag, " load_valid"}, 32'(LOAD_VALID), 32'(v.exp_lv));
                check({tag, " bus_error"}, 32'(BUS_ERROR), 32'(v.exp_err));
                check({tag, " misaligned"}, 32'(MISALIGNED), 32'(v.exp_mis));
                if (v.chk_load) check({tag, " load_data"}, LOAD_DATA, v.exp_load);
                check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(v.exp_stall));
                check({tag, " req_cycles"}, 32'(req_cnt), 32'(v.exp_req));
                MEM_READ = 1'b0; MEM_WRITE = 1'b0; BUS_ACK = 1'b0;
            end else begin
                if (STALL) stall_cnt++;
                if (BUS_REQ) begin
                    check({tag, " bus_addr"}, BUS_ADDR, v.exp_baddr);
                    check({tag, " bus_we"}, 32'(BUS_WE), 32'(v.exp_we));
                    check({tag, " bus_be"}, 32'(BUS_BE), 32'(v.exp_be));
                    if (v.exp_we) check({tag, " bus_wdata"}, BUS_WDATA, v.exp_wdata);
                    BUS_ACK = (wait_cyc == v.ack_wait);
                    wait_cyc++;
                    req_cnt++;
                end else begin
                    BUS_ACK = 1'b0;
                end
            end
            @(negedge CLK);
        end
        if (!done) check({tag, " completion_timeout"}, 32'd0, 32'd1);
        #1;
        check({tag, " idle_stall"}, 32'(STALL), 32'd0);
        check({tag, " idle_lv"}, 32'(LOAD_VALID | BUS_ERROR | MISALIGNED), 32'd0);
    endtask

    initial begin
        //   rd wr f3      addr       wdata         rdata         ack  baddr      we be       bus_wdata     req stall lv err mis chk load
        add(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1,  32'h100, 1, 4'b1111, 32'hDEADBEEF, 2, 3, 0, 0, 0, 0, 32'h0);
        add(0, 1, 3'b000, 32'h203, 32'h000000A5, 32'h0,        0,  32'h200, 1, 4'b1000, 32'hA5A5A5A5, 1, 2, 0, 0, 0, 0, 32'h0);
        add(0, 1, 3'b001, 32'h202, 32'h1234BEEF, 32'h0,        0,  32'h200, 1, 4'b1100, 32'hBEEFBEEF, 1, 2, 0, 0, 0, 0, 32'h0);
        add(1, 0, 3'b000, 32'h101, 32'h0,        32'h12348000, 0,  32'h100, 0, 4'b0010, 32'h0,        1, 2, 1, 0, 0, 1, 32'hFFFFFF80);
        add(1, 0, 3'b100, 32'h101, 32'h0,        32'h12348000, 0,  32'h100, 0, 4'b0010, 32'h0,        1, 2, 1, 0, 0, 1, 32'h00000080);
        add(1, 0, 3'b001, 32'h102, 32'h0,        32'h80001234, 2,  32'h100, 0, 4'b1100, 32'h0,        3, 4, 1, 0, 0, 1, 32'hFFFF8000);
        add(1, 0, 3'b101, 32'h102, 32'h0,        32'h80001234, 0,  32'h100, 0, 4'b1100, 32'h0,        1, 2, 1, 0, 0, 1, 32'h00008000);
        add(1, 0, 3'b010, 32'h104, 32'h0,        32'hCAFEF00D, 0,  32'h104, 0, 4'b1111, 32'h0,        1, 2, 1, 0, 0, 1, 32'hCAFEF00D);
        add(1, 1, 3'b010, 32'h108, 32'h11111111, 32'h0BADF00D, 0,  32'h108, 0, 4'b1111, 32'h0,        1, 2, 1, 0, 0, 1, 32'h0BADF00D);
        add(1, 0, 3'b000, 32'h107, 32'h0,        32'h7F000000, 0,  32'h104, 0, 4'b1000, 32'h0,        1, 2, 1, 0, 0, 1, 32'h0000007F);
        add(1, 0, 3'b011, 32'h10C, 32'h0,        32'h89ABCDEF, 0,  32'h10C, 0, 4'b1111, 32'h0,        1, 2, 1, 0, 0, 1, 32'h89ABCDEF);
        add(1, 0, 3'b010, 32'h110, 32'h0,        32'h55555555, 999, 32'h110, 0, 4'b1111, 32'h0,       16, 17, 0, 1, 0, 1, 32'h0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        add(1, 0, 3'b010, 32'h102, 32'h0,        32'h12345678, 0,  32'h100, 0, 4'b1111, 32'h0,        0, 1, 0, 0, 1, 1, 32'h0);
        add(0, 1, 3'b001, 32'h201, 32'h0000ABCD, 32'h0,        0,  32'h200, 1, 4'b0011, 32'hABCDABCD, 0, 1, 0, 0, 1, 0, 32'h0);
`else
        add(1, 0, 3'b010, 32'h102, 32'h0,        32'h12345678, 0,  32'h100, 0, 4'b1111, 32'h0,        1, 2, 1, 0, 0, 1, 32'h12345678);
        add(0, 1, 3'b001, 32'h201, 32'h0000ABCD, 32'h0,        0,  32'h200, 1, 4'b0011, 32'hABCDABCD, 1, 2, 0, 0, 0, 0, 32'h0);
`endif

        // Reset state
        repeat (2) @(negedge CLK);
        #1;
        check("rst bus_req", 32'(BUS_REQ), 32'd0);
        check("rst stall", 32'(STALL), 32'd0);
        check("rst bus_addr", BUS_ADDR, 32'd0);
        check("rst bus_be", 32'(BUS_BE), 32'd0);
        check("rst bus_wdata", BUS_WDATA, 32'd0);
        check("rst load_data", LOAD_DATA, 32'd0);
        check("rst pulses", 32'({LOAD_VALID, BUS_ERROR, MISALIGNED, BUS_WE}), 32'd0);
        RST = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Reset while an access is waiting for ACK
        @(negedge CLK);
        MEM_READ = 1'b1; FUNC3 = 3'b010; ADDRESS = 32'h120; BUS_RDATA = 32'hA5A5A5A5;
        @(negedge CLK);
        #1;
        check("midrst req_before", 32'(BUS_REQ), 32'd1);
        RST = 1'b0;
        #1;
        check("midrst req_drop", 32'(BUS_REQ), 32'd0);
        check("midrst stall_drop", 32'(STALL), 32'd0);
        MEM_READ = 1'b0;
        BUS_ACK = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        #1;
        check("midrst late_ack_lv", 32'(LOAD_VALID), 32'd0);
        check("midrst late_ack_stall", 32'(STALL), 32'd0);
        check("midrst late_ack_req", 32'(BUS_REQ), 32'd0);
        check("midrst load_data", LOAD_DATA, 32'd0);
        BUS_ACK = 1'b0;
        begin
            vec_t v;
            v.rd = 1; v.wr = 0; v.f3 = 3'b010; v.addr = 32'h124; v.wdata = 32'h0;
            v.rdata = 32'h600DF00D; v.ack_wait = 0; v.exp_baddr = 32'h124;
            v.exp_we = 0; v.exp_be = 4'b1111; v.exp_wdata = 32'h0;
            v.exp_req = 1; v.exp_stall = 2; v.exp_lv = 1; v.exp_err = 0;
            v.exp_mis = 0; v.chk_load = 1; v.exp_load = 32'h600DF00D;
            run_vec(v, 99);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
